// File: rtl/psk_mod_dac_ctrl.sv
// ============================================================================
// Module   : psk_mod_dac_ctrl
// Brief    : PRBS-driven BPSK/QPSK symbol source with optional differential
//            encoding, plus saturating offset-binary DAC formatter (I and Q).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psk_mod_dac_ctrl #(
    parameter int SYM_DIV    = 17,
    parameter int PRBS_ORDER = 9,
    parameter int FILT_W     = 16,
    parameter int DAC_W      = 14,
    parameter int SHIFT      = 2,
    parameter int DAC_OFFSET = 8192
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     mode,
    input  logic                     diff_en,
    output logic                     sym_stb,
    output logic                     bit_out,
    output logic [1:0]               map_i,
    output logic [1:0]               map_q,
    input  logic signed [FILT_W-1:0] filt_i,
    input  logic signed [FILT_W-1:0] filt_q,
    output logic [DAC_W-1:0]         dac_i,
    output logic [DAC_W-1:0]         dac_q,
    output logic                     sat
);

    localparam int c_cnt_w = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
    localparam int c_tap_b = (PRBS_ORDER == 7)  ? 6  :
                             (PRBS_ORDER == 9)  ? 5  :
                             (PRBS_ORDER == 15) ? 14 : 18;
    localparam int c_vw      = FILT_W + 2;
    localparam int c_dac_max = (1 << DAC_W) - 1;
    localparam int c_dac_rst_i = (DAC_OFFSET < 0) ? 0 :
                                 (DAC_OFFSET > c_dac_max) ? c_dac_max : DAC_OFFSET;
    localparam logic [DAC_W-1:0]        c_dac_rst = DAC_W'(c_dac_rst_i);
    localparam logic signed [c_vw-1:0]  c_off_v   = c_vw'(DAC_OFFSET);
    localparam logic signed [c_vw-1:0]  c_max_v   = c_vw'(c_dac_max);
    localparam logic [c_cnt_w-1:0]      c_cnt_end = c_cnt_w'(SYM_DIV - 1);
    localparam logic [1:0]              c_pos     = 2'b01;
    localparam logic [1:0]              c_neg     = 2'b11;

    logic [c_cnt_w-1:0]    r_cnt;
    logic [PRBS_ORDER-1:0] r_lfsr;
    logic                  r_i_prev;
    logic                  r_q_prev;
    logic                  r_sym_stb;
    logic                  r_bit_out;
    logic [1:0]            r_map_i;
    logic [1:0]            r_map_q;
    logic [DAC_W-1:0]      r_dac_i;
    logic [DAC_W-1:0]      r_dac_q;
    logic                  r_sat;

    logic                  w_tick;
    logic [PRBS_ORDER-1:0] w_lfsr1;
    logic [PRBS_ORDER-1:0] w_lfsr2;
    logic                  w_i_bit;
    logic                  w_q_bit;
    logic [DAC_W:0]        w_dac_i;
    logic [DAC_W:0]        w_dac_q;

    // Fibonacci shift-left step: feedback enters at the LSB.
    function automatic logic [PRBS_ORDER-1:0] lfsr_step(input logic [PRBS_ORDER-1:0] s);
        return {s[PRBS_ORDER-2:0], s[PRBS_ORDER-1] ^ s[c_tap_b-1]};
    endfunction

    // Returns {clip, code}: shift, re-bias to mid-scale, then clamp to DAC range.
    function automatic logic [DAC_W:0] dac_code(input logic signed [FILT_W-1:0] f);
        logic signed [FILT_W-1:0] s;
        logic signed [c_vw-1:0]   v;
        s = f >>> SHIFT;
        v = $signed({{2{s[FILT_W-1]}}, s}) + c_off_v;
        if (v[c_vw-1])
            return {1'b1, {DAC_W{1'b0}}};
        else if (v > c_max_v)
            return {1'b1, {DAC_W{1'b1}}};
        else
            return {1'b0, v[DAC_W-1:0]};
    endfunction

    always_comb begin
        w_tick  = en && (r_cnt == c_cnt_end);
        w_lfsr1 = lfsr_step(r_lfsr);
        w_lfsr2 = lfsr_step(w_lfsr1);
        w_i_bit = r_lfsr[PRBS_ORDER-1]  ^ (diff_en & r_i_prev);
        w_q_bit = w_lfsr1[PRBS_ORDER-1] ^ (diff_en & r_q_prev);
        w_dac_i = dac_code(filt_i);
        w_dac_q = dac_code(filt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_lfsr    <= '1;
            r_i_prev  <= 1'b0;
            r_q_prev  <= 1'b0;
            r_sym_stb <= 1'b0;
            r_bit_out <= 1'b0;
            r_map_i   <= 2'b00;
            r_map_q   <= 2'b00;
        end else begin
            r_sym_stb <= w_tick;
            if (en)
                r_cnt <= w_tick ? '0 : r_cnt + c_cnt_w'(1);
            if (w_tick) begin
                r_lfsr    <= mode ? w_lfsr2 : w_lfsr1;
                r_i_prev  <= w_i_bit;
                r_bit_out <= w_i_bit;
                r_map_i   <= w_i_bit ? c_pos : c_neg;
                // Q history only advances when a Q bit is actually produced.
                if (mode) begin
                    r_q_prev <= w_q_bit;
                    r_map_q  <= w_q_bit ? c_pos : c_neg;
                end else begin
                    r_map_q  <= 2'b00;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dac_i <= c_dac_rst;
            r_dac_q <= c_dac_rst;
            r_sat   <= 1'b0;
        end else begin
            r_dac_i <= w_dac_i[DAC_W-1:0];
            r_dac_q <= w_dac_q[DAC_W-1:0];
            r_sat   <= r_sat | w_dac_i[DAC_W] | w_dac_q[DAC_W];
        end
    end

    assign sym_stb = r_sym_stb;
    assign bit_out = r_bit_out;
    assign map_i   = r_map_i;
    assign map_q   = r_map_q;
    assign dac_i   = r_dac_i;
    assign dac_q   = r_dac_q;
    assign sat     = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_psk_mod_dac_ctrl.sv
// ============================================================================
// Module   : tb_psk_mod_dac_ctrl
// Brief    : Directed self-checking bench for psk_mod_dac_ctrl (two instances:
//            default SHIFT=2 and SHIFT=1 for saturation).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psk_mod_dac_ctrl;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst, en, mode, diff_en;
    logic signed [15:0] filt_i, filt_q, filt_i2, filt_q2;
    logic        sym_stb, bit_out, sat;
    logic [1:0]  map_i, map_q;
    logic [13:0] dac_i, dac_q;
    logic        sym_stb2, bit_out2, sat2;
    logic [1:0]  map_i2, map_q2;
    logic [13:0] dac_i2, dac_q2;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] ref_lfsr;
    logic       ref_ip, ref_qp;

    psk_mod_dac_ctrl #(
        .SYM_DIV(17), .PRBS_ORDER(9), .FILT_W(16), .DAC_W(14), .SHIFT(2), .DAC_OFFSET(8192)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .diff_en(diff_en),
        .sym_stb(sym_stb), .bit_out(bit_out), .map_i(map_i), .map_q(map_q),
        .filt_i(filt_i), .filt_q(filt_q), .dac_i(dac_i), .dac_q(dac_q), .sat(sat)
    );

    psk_mod_dac_ctrl #(
        .SYM_DIV(17), .PRBS_ORDER(9), .FILT_W(16), .DAC_W(14), .SHIFT(1), .DAC_OFFSET(8192)
    ) u_dut_s1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .diff_en(diff_en),
        .sym_stb(sym_stb2), .bit_out(bit_out2), .map_i(map_i2), .map_q(map_q2),
        .filt_i(filt_i2), .filt_q(filt_q2), .dac_i(dac_i2), .dac_q(dac_q2), .sat(sat2)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [8:0] ref_step(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

    function automatic logic [1:0] sym(input logic b);
        return b ? 2'b01 : 2'b11;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) next_cycle();
        rst = 1'b0;
        ref_lfsr = '1;
        ref_ip   = 1'b0;
        ref_qp   = 1'b0;
    endtask

    // Count edges until sym_stb is seen; an expired bound is a failed check.
    task automatic wait_stb(output int n);
        n = 0;
        do begin
            next_cycle();
            n++;
        end while (!sym_stb && n < 200);
        if (!sym_stb) check("stb_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic b0, b1, ib, qb;
        logic signed [15:0] vin [5];
        logic [13:0]        vexp[5];
        vin[0] = 16'sd32767;  vexp[0] = 14'h3FFF;
        vin[1] = 16'sd0;      vexp[1] = 14'h2000;
        vin[2] = -16'sd32768; vexp[2] = 14'h0000;
        vin[3] = 16'sd100;    vexp[3] = 14'd8217;
        vin[4] = -16'sd1;     vexp[4] = 14'd8191;

        rst = 1'b1; en = 1'b0; mode = 1'b0; diff_en = 1'b0;
        filt_i = '0; filt_q = '0; filt_i2 = '0; filt_q2 = '0;

        // Reset state and plain BPSK from the all-ones seed.
        do_reset(3);
        check("rst_stb", sym_stb, 0);
        check("rst_bit", bit_out, 0);
        check("rst_map_i", map_i, 2'b00);
        check("rst_map_q", map_q, 2'b00);
        check("rst_dac_i", dac_i, 14'h2000);
        check("rst_dac_q", dac_q, 14'h2000);
        check("rst_sat", sat, 0);
        check("rst_sat2", sat2, 0);
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            wait_stb(n);
            check("t1_period", n, 17);
            b0 = ref_lfsr[8];
            ref_lfsr = ref_step(ref_lfsr);
            if (k < 9) check("t1_seed_map_i", map_i, 2'b01);
            check("t1_map_i", map_i, sym(b0));
            check("t1_map_q", map_q, 2'b00);
            check("t1_bit", bit_out, b0);
            check("t1_dac_i", dac_i, 14'h2000);
        end

        // Differential BPSK.
        en = 1'b0; diff_en = 1'b1; mode = 1'b0;
        do_reset(1);
        en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            wait_stb(n);
            b0 = ref_lfsr[8];
            ref_lfsr = ref_step(ref_lfsr);
            ib = b0 ^ ref_ip;
            ref_ip = ib;
            if (k < 9) check("t2_alt_bit", bit_out, (k % 2 == 0) ? 1 : 0);
            check("t2_map_i", map_i, sym(ib));
            check("t2_map_q", map_q, 2'b00);
        end

        // QPSK PRBS over 600 symbols.
        en = 1'b0; diff_en = 1'b0; mode = 1'b1;
        do_reset(1);
        en = 1'b1;
        for (int k = 0; k < 600; k++) begin
            wait_stb(n);
            b0 = ref_lfsr[8];
            ref_lfsr = ref_step(ref_lfsr);
            b1 = ref_lfsr[8];
            ref_lfsr = ref_step(ref_lfsr);
            check("t3_map_i", map_i, sym(b0));
            check("t3_map_q", map_q, sym(b1));
        end

        // Differential QPSK.
        en = 1'b0; diff_en = 1'b1; mode = 1'b1;
        do_reset(1);
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wait_stb(n);
            b0 = ref_lfsr[8];
            ref_lfsr = ref_step(ref_lfsr);
            b1 = ref_lfsr[8];
            ref_lfsr = ref_step(ref_lfsr);
            ib = b0 ^ ref_ip;  ref_ip = ib;
            qb = b1 ^ ref_qp;  ref_qp = qb;
            check("t3d_map_i", map_i, sym(ib));
            check("t3d_map_q", map_q, sym(qb));
        end

        // DAC scaling, SHIFT=2, with one-cycle latency.
        en = 1'b0; mode = 1'b0; diff_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            filt_i = vin[k];
            filt_q = vin[(k + 2) % 5];
            #1;
            if (k > 0) check("t4_hold_i", dac_i, vexp[k-1]);
            next_cycle();
            check("t4_dac_i", dac_i, vexp[k]);
            check("t4_dac_q", dac_q, vexp[(k + 2) % 5]);
            check("t4_sat", sat, 0);
        end
        filt_i = '0; filt_q = '0;

        // Saturation with SHIFT=1: sticky until reset.
        check("t5_sat2_pre", sat2, 0);
        filt_q2 = 16'sd32767;
        next_cycle();
        check("t5_dac_q2", dac_q2, 14'h3FFF);
        check("t5_sat2", sat2, 1);
        filt_q2 = '0;
        repeat (3) begin
            next_cycle();
            check("t5_dac_q2_zero", dac_q2, 14'h2000);
            check("t5_sat2_held", sat2, 1);
        end
        check("t5_sat_main", sat, 0);
        do_reset(1);
        check("t5_sat2_cleared", sat2, 0);
        filt_i2 = -16'sd32768;
        next_cycle();
        check("t5_dac_i2_low", dac_i2, 14'h0000);
        check("t5_sat2_low", sat2, 1);
        filt_i2 = 16'sd1000;
        next_cycle();
        check("t5_dac_i2_mid", dac_i2, 14'd8692);
        filt_i2 = '0;

        // en gap delays the symbol; reset at cnt=8 restarts everything.
        en = 1'b0; mode = 1'b0; diff_en = 1'b0;
        do_reset(1);
        en = 1'b1;
        wait_stb(n);
        check("t6_first", n, 17);
        repeat (8) next_cycle();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t6_gap_stb", sym_stb, 0);
            next_cycle();
        end
        en = 1'b1;
        wait_stb(n);
        check("t6_resume", n, 9);
        repeat (8) next_cycle();
        rst = 1'b1;
        next_cycle();
        check("t6_rst_stb", sym_stb, 0);
        check("t6_rst_bit", bit_out, 0);
        check("t6_rst_map_i", map_i, 2'b00);
        check("t6_rst_map_q", map_q, 2'b00);
        check("t6_rst_dac_i", dac_i, 14'h2000);
        rst = 1'b0;
        ref_lfsr = '1;
        for (int k = 0; k < 12; k++) begin
            wait_stb(n);
            check("t6_period", n, 17);
            b0 = ref_lfsr[8];
            ref_lfsr = ref_step(ref_lfsr);
            check("t6_map_i", map_i, sym(b0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
